// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 keyboard front end.
`default_nettype none

package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_DECODE = 3'd4
  } ps2_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [6:0] ASC_NUL    = 7'h00;
  localparam logic [6:0] ASC_CR     = 7'h0D;
  localparam logic [6:0] ASC_ESC    = 7'h1B;
  localparam logic [6:0] ASC_SPACE  = 7'h20;
  localparam logic [6:0] ASC_RUBOUT = 7'h5F;

  function automatic logic is_shift_code(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_scancode_rom.sv
// ps2_scancode_rom: set-2 scancode to 7-bit ASCII, zero for unmapped codes.
// KBD_SHIFT_EN adds lowercase letters and the shifted US symbol table.
`default_nettype none

module ps2_scancode_rom
  import kbd_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  output logic [6:0] ascii
);

  logic [6:0] base;

  // Unshifted glyphs; letters are stored uppercase.
  always_comb begin
    base = ASC_NUL;
    case (scancode)
      8'h1C: base = 7'h41; 8'h32: base = 7'h42; 8'h21: base = 7'h43; 8'h23: base = 7'h44;
      8'h24: base = 7'h45; 8'h2B: base = 7'h46; 8'h34: base = 7'h47; 8'h33: base = 7'h48;
      8'h43: base = 7'h49; 8'h3B: base = 7'h4A; 8'h42: base = 7'h4B; 8'h4B: base = 7'h4C;
      8'h3A: base = 7'h4D; 8'h31: base = 7'h4E; 8'h44: base = 7'h4F; 8'h4D: base = 7'h50;
      8'h15: base = 7'h51; 8'h2D: base = 7'h52; 8'h1B: base = 7'h53; 8'h2C: base = 7'h54;
      8'h3C: base = 7'h55; 8'h2A: base = 7'h56; 8'h1D: base = 7'h57; 8'h22: base = 7'h58;
      8'h35: base = 7'h59; 8'h1A: base = 7'h5A;
      8'h16: base = 7'h31; 8'h1E: base = 7'h32; 8'h26: base = 7'h33; 8'h25: base = 7'h34;
      8'h2E: base = 7'h35; 8'h36: base = 7'h36; 8'h3D: base = 7'h37; 8'h3E: base = 7'h38;
      8'h46: base = 7'h39; 8'h45: base = 7'h30;
      8'h0E: base = 7'h60; 8'h4E: base = 7'h2D; 8'h55: base = 7'h3D; 8'h54: base = 7'h5B;
      8'h5B: base = 7'h5D; 8'h5D: base = 7'h5C; 8'h4C: base = 7'h3B; 8'h52: base = 7'h27;
      8'h41: base = 7'h2C; 8'h49: base = 7'h2E; 8'h4A: base = 7'h2F;
      SC_SPACE: base = ASC_SPACE;
      SC_ENTER: base = ASC_CR;
      SC_BKSP:  base = ASC_RUBOUT;
      SC_ESC:   base = ASC_ESC;
      default:  base = ASC_NUL;
    endcase
  end

`ifdef KBD_SHIFT_EN
  logic [6:0] shifted;

  always_comb begin
    shifted = base;
    case (scancode)
      8'h16: shifted = 7'h21; 8'h1E: shifted = 7'h40; 8'h26: shifted = 7'h23; 8'h25: shifted = 7'h24;
      8'h2E: shifted = 7'h25; 8'h36: shifted = 7'h5E; 8'h3D: shifted = 7'h26; 8'h3E: shifted = 7'h2A;
      8'h46: shifted = 7'h28; 8'h45: shifted = 7'h29;
      8'h0E: shifted = 7'h7E; 8'h4E: shifted = 7'h5F; 8'h55: shifted = 7'h2B; 8'h54: shifted = 7'h7B;
      8'h5B: shifted = 7'h7D; 8'h5D: shifted = 7'h7C; 8'h4C: shifted = 7'h3A; 8'h52: shifted = 7'h22;
      8'h41: shifted = 7'h3C; 8'h49: shifted = 7'h3E; 8'h4A: shifted = 7'h3F;
      default: shifted = base;
    endcase
    if (base >= 7'h41 && base <= 7'h5A)
      ascii = shift ? base : (base | 7'h20);
    else
      ascii = shift ? shifted : base;
  end
`else
  logic unused_shift;
  assign unused_shift = shift;
  assign ascii        = base;
`endif

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 frame receiver, make/break tracking and Apple-1 style key latch.
// Define KBD_SHIFT_EN to track shift (lowercase letters and shifted symbols).
`default_nettype none

module ps2_keyboard
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       keystrobe,
  output logic [7:0] keycode,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, strobe;
  logic [FW-1:0] filt_cnt;

  // Filtered clock changes only after FILTER_LEN samples of the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      strobe    <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        strobe   <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  ps2_state_t    state, state_next;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          parity_bit, err_next, in_frame, timeout;
  logic [TW-1:0] to_cnt;

  assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
  assign timeout  = in_frame && !strobe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe) begin
          if (!data_sync[1]) state_next = ST_DATA;
          else               err_next   = 1'b1;
        end
      end
      ST_DATA: begin
        if (timeout) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else if (strobe && bit_cnt == 3'd7) begin
          state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (timeout) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else if (strobe) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timeout) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else if (strobe) begin
          if (data_sync[1] && (^{shreg, parity_bit})) begin
            state_next = ST_DECODE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_DECODE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= err_next;
      to_cnt    <= (!in_frame || strobe) ? '0 : to_cnt + TW'(1);
      if (strobe) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: parity_bit <= data_sync[1];
          default:   ;
        endcase
      end
    end
  end

  logic       brk, ext, shift_val, is_prefix, load, ks_d;
  logic [6:0] rom_ascii;

`ifdef KBD_SHIFT_EN
  logic shift_q;
  assign shift_val = shift_q;
`else
  assign shift_val = 1'b0;
`endif

  ps2_scancode_rom u_rom (
    .scancode (shreg),
    .shift    (shift_val),
    .ascii    (rom_ascii)
  );

  assign is_prefix = (shreg == SC_EXT) || (shreg == SC_BRK);
  assign load      = (state == ST_DECODE) && !is_prefix && !brk && !ext &&
                     !is_shift_code(shreg) && (rom_ascii != ASC_NUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk <= 1'b0;
      ext <= 1'b0;
`ifdef KBD_SHIFT_EN
      shift_q <= 1'b0;
`endif
    end else if (state == ST_DECODE) begin
      if (shreg == SC_EXT) begin
        ext <= 1'b1;
      end else if (shreg == SC_BRK) begin
        brk <= 1'b1;
      end else begin
`ifdef KBD_SHIFT_EN
        if (is_shift_code(shreg) && !ext) shift_q <= !brk;
`endif
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  // A load in the same cycle as an acknowledge keeps the key pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keycode <= 8'h00;
      ks_d    <= 1'b0;
    end else begin
      ks_d <= keystrobe;
      if (load)                    keycode    <= {1'b1, rom_ascii};
      else if (keystrobe && !ks_d) keycode[7] <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed and randomized PS/2 frames checked against a keyboard model.
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_keyboard;

  localparam int HALF    = 25;
  localparam int TIMEOUT = 20000;
`ifdef KBD_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, keystrobe = 1'b0;
  logic [7:0] keycode;
  logic       frame_err;

  int compared = 0, mismatched = 0, err_pulses = 0, err_cycles = 0;
  logic err_prev = 1'b0;

  ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keystrobe (keystrobe),
    .keycode   (keycode),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (frame_err && !err_prev) err_pulses++;
    err_prev = frame_err;
  end

  byte unsigned letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_sc[10]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  byte unsigned punct_sc[11]  = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  string digit_lo = "1234567890", digit_hi = "!@#$%^&*()";
  byte unsigned punct_lo[11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  byte unsigned punct_hi[11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};

  bit m_pend, m_brk, m_ext, m_shift;
  logic [6:0] m_ascii;

  function automatic logic [6:0] ref_ascii(input logic [7:0] sc, input bit sh);
    byte c;
    for (int i = 0; i < 26; i++)
      if (sc == letter_sc[i]) return 7'(8'h41 + i + ((SHIFT_EN && !sh) ? 32 : 0));
    for (int i = 0; i < 10; i++)
      if (sc == digit_sc[i]) begin
        c = (SHIFT_EN && sh) ? digit_hi[i] : digit_lo[i];
        return c[6:0];
      end
    for (int i = 0; i < 11; i++)
      if (sc == punct_sc[i]) begin
        c = (SHIFT_EN && sh) ? punct_hi[i] : punct_lo[i];
        return c[6:0];
      end
    if (sc == 8'h29) return 7'h20;
    if (sc == 8'h5A) return 7'h0D;
    if (sc == 8'h66) return 7'h5F;
    if (sc == 8'h76) return 7'h1B;
    return 7'h00;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_brk = 0; m_ext = 0; m_shift = 0; m_ascii = 7'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [6:0] a;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_brk) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      m_brk = 0; m_ext = 0;
    end else if (m_ext) m_ext = 0;
    else if (b == 8'h12 || b == 8'h59) m_shift = 1;
    else begin
      a = ref_ascii(b, m_shift);
      if (a != 7'h00) begin m_pend = 1; m_ascii = a; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_kc(input string tag);
    check(tag, {24'h0, keycode}, {24'h0, m_pend, m_ascii});
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits, input bit ack_at_load);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (ack_at_load && i == 10) begin
        repeat (11) @(posedge clk);
        @(negedge clk);
        keystrobe = 1'b1;
        repeat (HALF - 12) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b);
    send_bits(b, 1'b0, 11, 1'b0);
    model_byte(b);
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    keystrobe = 1'b1;
    m_pend = 0;
    @(negedge clk);
    check_kc(tag);
    keystrobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_keycode", {24'h0, keycode}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    frame(8'h1C);
    check_kc("make_1C");
    check("no_err_valid", err_pulses, 0);

    frame(8'hF0);
    frame(8'h1C);
    check_kc("break_1C");
    ack("ack_clears_bit7");

    send_bits(8'h1C, 1'b1, 11, 1'b0);
    check("parity_err_pulses", err_pulses, 1);
    check("parity_err_width", err_cycles, 1);
    check_kc("parity_keycode");

    send_bits(8'h1C, 1'b0, 6, 1'b0);
    repeat (TIMEOUT - 200) @(negedge clk);
    check("timeout_not_early", err_pulses, 1);
    repeat (400) @(negedge clk);
    check("timeout_err_pulses", err_pulses, 2);
    check("timeout_err_width", err_cycles, 2);
    frame(8'h5A);
    check_kc("after_timeout_5A");

    frame(8'h1C);
    check_kc("pending_1C");
    send_bits(8'h32, 1'b0, 11, 1'b1);
    m_pend = 0;
    model_byte(8'h32);
    check_kc("load_beats_ack");
    keystrobe = 1'b0;
    repeat (3) @(negedge clk);

    frame(8'h12);
    frame(8'h16);
    check_kc("shift_16");
    frame(8'hF0);
    frame(8'h12);
    frame(8'h16);
    check_kc("unshift_16");
    frame(8'h1C);
    check_kc("plain_1C");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: b = letter_sc[$urandom_range(0, 25)];
        3:       b = digit_sc[$urandom_range(0, 9)];
        4:       b = punct_sc[$urandom_range(0, 10)];
        5:       b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
        6:       b = 8'hF0;
        7:       b = 8'hE0;
        8:       b = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h76;
        default: b = 8'($urandom);
      endcase
      frame(b);
      check_kc("random_frame");
      if ($urandom_range(0, 3) == 0) ack("random_ack");
    end
    check("random_no_err", err_pulses, 2);

    send_bits(8'h1C, 1'b0, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_kc("midframe_reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midframe_reset_no_err", err_pulses, 2);
    frame(8'h1C);
    check_kc("after_reset_1C");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard front end that produces the Apple-1-style `keycode` byte consumed by the CPU bus decoder at $D010/$D011. It samples the raw PS/2 clock/data lines, deserialises 11-bit device-to-host frames, and tracks the make/break and prefix protocol. It translates scancodes (set 2) to 7-bit ASCII and holds the result in a latch whose bit 7 is the "key available" flag. It sits directly upstream of the top level's keyboard read path and is cleared by that path's `keystrobe`.

## Interface
- FILTER_LEN, 8: consecutive equal samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 20000: clk cycles without a filtered falling edge mid-frame before the frame is abandoned.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- keystrobe  in  1  level from bus decoder; its rising edge acknowledges the pending key.
- keycode  out  8  bit 7 = key pending; bits 6:0 = ASCII of the last key.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Reset: keycode=8'h00, frame_err=0, FSM=IDLE, break/ext/shift flags=0, filter and timeout counters=0.
- Synchronise both lines with 2 flops. ps2_clk passes a FILTER_LEN stability filter. A filtered 1→0 transition is a sample strobe; ps2_data (synchronised) is sampled on it.
- FSM states and transitions:
  - IDLE: on strobe with data=0 → DATA, bit count 0. Strobe with data=1 → frame_err, stay in IDLE.
  - DATA: shift in LSB first. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: if stop=1 and the XOR of data and parity is 1 (odd parity) → DECODE. Otherwise → frame_err, then IDLE.
  - DECODE: one cycle, then → IDLE.
- In DATA/PARITY/STOP, the timeout counter resets on each strobe. Reaching TIMEOUT_CYCLES → frame_err, then IDLE, with the partial byte discarded and the flags untouched.
- DECODE rules for byte b:
  - E0: set ext.
  - F0: set brk.
  - Otherwise, if brk: 12/59 clears shift; all other codes are ignored. Then clear brk and ext.
  - Otherwise (make), if ext: ignore the code (extended keys unsupported). Then clear ext.
  - Otherwise (make), 12/59 sets shift. Any other code looks up the ASCII value. A nonzero result loads keycode={1'b1, ascii}; a zero result is ignored. Then clear ext.
- Map: letters, digits, punctuation; 29→20h space, 5A→0Dh CR, 66→5Fh '_' (rubout), 76→1Bh ESC. Unmapped → 0.
- Ack: a rising edge of keystrobe (registered previous value) clears keycode[7]. Bits 6:0 are held.
- Overrun: a new key while bit 7=1 overwrites bits 6:0, and bit 7 stays 1. If a key load and an ack edge happen in the same cycle, the load wins and bit 7=1.

## Timing
- Sample strobe occurs 2 (sync) + FILTER_LEN + 1 cycles after the raw ps2_clk fall.
- keycode updates on the 2nd clk edge after the stop-bit strobe: one edge to enter DECODE, one to register.
- frame_err asserts one cycle after the failing strobe or timeout. Its width is exactly 1.
- keycode[7] clears one cycle after the keystrobe rising edge.
- Reset mid-frame: immediate return to IDLE. No keycode load and no frame_err.

## Configuration
- KBD_SHIFT_EN defined: shift is tracked. Unshifted letters → lowercase (61h–7Ah). Shifted letters → uppercase. Shifted digits and punctuation → US symbols (1→'!', 2→'@', …).
- Undefined: shift codes are consumed but have no effect. Letters are always uppercase (41h–5Ah). Digits and punctuation always map to their unshifted glyphs. The shift flag and shifted table are not built.

## Structure
- Package kbd_pkg holds:
  - FSM state enum.
  - Scancode constants: SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_ENTER=5A, SC_BKSP=66, SC_ESC=76, SC_SPACE=29.
  - ASCII constants.
- Sub-module ps2_scancode_rom: combinational (scancode[7:0], shift) → ascii[6:0]. It holds the unshifted table and, when KBD_SHIFT_EN is defined, the shifted table.

## Test plan
- Macro off. Frame 1C (odd parity, stop 1) → keycode=C1h two cycles after the stop strobe; frame_err stays 0.
- With keycode=C1h: frames F0, 1C → keycode stays C1h. Then a keystrobe rising edge → keycode=41h one cycle later.
- Frame 1C with wrong parity → one-cycle frame_err pulse; keycode unchanged (00h after reset).
- Frame truncated after 5 data bits, then idle > TIMEOUT_CYCLES → one frame_err pulse. The next valid frame 5A → keycode=8Dh.
- Keycode pending C1h, frame 32 ('B') whose load coincides with a keystrobe rising edge → keycode=C2h.
- Macro on. Frames 12, 16, F0 12, 16 → keycode A1h ('!'), then B1h ('1'). Frame 1C unshifted → E1h.
